// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Optional early termination is enabled by defining EARLY_TERM_EN.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    SEL_0,
    SEL_P1,
    SEL_P2,
    SEL_M1,
    SEL_M2
  } booth_sel_t;

  function automatic int steps(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: 3-bit multiplier group to partial-product select.
// Purely combinational; one instance serves every step of the multiplier.
import booth_pkg::*;

module booth_recode (
  input  logic [2:0] i_grp,
  output booth_sel_t o_sel
);

  always_comb begin
    o_sel = SEL_0;
    unique case (i_grp)
      3'b000, 3'b111: o_sel = SEL_0;
      3'b001, 3'b010: o_sel = SEL_P1;
      3'b011:         o_sel = SEL_P2;
      3'b100:         o_sel = SEL_M2;
      3'b101, 3'b110: o_sel = SEL_M1;
      default:        o_sel = SEL_0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one bit-pair per clock, start/done handshake.
// Define EARLY_TERM_EN to finish as soon as the remaining groups recode to zero.
import booth_pkg::*;

module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int N  = steps(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH+2:0] r_q;
  logic [PW-1:0]    r_m;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  booth_sel_t       w_sel;
  logic [PW-1:0]    w_term;
  logic [PW-1:0]    w_acc_nxt;
  logic             w_load;
  logic             w_last;
  logic             w_ext_q;
  logic             w_ext_m;

  assign w_ext_q = signed_op & mplier[WIDTH-1];
  assign w_ext_m = signed_op & mcand[WIDTH-1];

  // r_q[2:0] is always the current group {Qx[2k+1],Qx[2k],Qx[2k-1]}
  booth_recode u_recode (
    .i_grp (r_q[2:0]),
    .o_sel (w_sel)
  );

  // Bits above 2*WIDTH never reach the product, so the sum is kept mod 2^(2*WIDTH)
  always_comb begin
    w_term = '0;
    unique case (w_sel)
      SEL_0:   w_term = '0;
      SEL_P1:  w_term = r_m;
      SEL_P2:  w_term = r_m << 1;
      SEL_M1:  w_term = -r_m;
      SEL_M2:  w_term = -(r_m << 1);
      default: w_term = '0;
    endcase
  end

  assign w_acc_nxt = r_acc + w_term;

`ifdef EARLY_TERM_EN
  logic w_rest_eq;
  assign w_rest_eq = (&r_q[WIDTH+2:2]) | ~(|r_q[WIDTH+2:2]);
  assign w_last    = (r_cnt == CW'(N - 1)) | w_rest_eq;
`else
  assign w_last    = (r_cnt == CW'(N - 1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_q   <= {w_ext_q, w_ext_q, mplier, 1'b0};
        r_m   <= {{WIDTH{w_ext_m}}, mcand};
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_q   <= {{2{r_q[WIDTH+2]}}, r_q[WIDTH+2:2]};
        r_m   <= r_m << 2;
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_hi <= w_acc_nxt[PW-1:WIDTH];
          r_lo <= w_acc_nxt[WIDTH-1:0];
        end
      end
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign prod_hi = r_hi;
  assign prod_lo = r_lo;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (WIDTH=32): directed corners plus random vectors.
// Latency expectations follow EARLY_TERM_EN when it is defined.
module tb_booth_mul_seq;

  localparam int W = 32;

`ifdef EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic         clk;
  logic         clr;
  logic         start;
  logic         signed_op;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic         busy;
  logic         done;
  logic [W-1:0] prod_hi;
  logic [W-1:0] prod_lo;

  int n_chk;
  int n_err;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .signed_op (signed_op),
    .mcand     (mcand),
    .mplier    (mplier),
    .busy      (busy),
    .done      (done),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa;
    logic [63:0] xb;
    xa = s ? {{32{a[31]}}, a} : {32'b0, a};
    xb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  // Steps needed when stopping once the untouched multiplier bits are uniform
  function automatic int et_lat(input logic s, input logic [31:0] b);
    logic [33:0] qx;
    logic        all0;
    logic        all1;
    qx = {s & b[31], s & b[31], b};
    for (int k = 0; k < 17; k++) begin
      all0 = 1'b1;
      all1 = 1'b1;
      for (int i = 2 * k + 1; i < 34; i++) begin
        all0 = all0 & ~qx[i];
        all1 = all1 & qx[i];
      end
      if (all0 || all1) return k + 1;
    end
    return 17;
  endfunction

  function automatic int exp_lat(input logic s, input logic [31:0] b);
    return ET ? et_lat(s, b) : 17;
  endfunction

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    signed_op = s;
    mcand     = a;
    mplier    = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mcand  = $urandom;
    mplier = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 40) chk("timeout", 64'(done), 64'd1);
  endtask

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string tag);
    int lat;
    launch(s, a, b);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    chk({tag, "_prod"}, {prod_hi, prod_lo}, exp);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(s, b)));
    @(posedge clk);
    #1;
    chk({tag, "_done1"}, 64'(done), 64'd0);
  endtask

  initial begin
    int          lat;
    logic        saw;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] corner [6];

    n_chk     = 0;
    n_err     = 0;
    clr       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    mcand     = '0;
    mplier    = '0;
    corner    = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
    @(negedge clk);
    clr = 1'b0;

    do_op(1'b0, 32'd7, 32'd3, 64'd21, "u7x3");
    if (ET) chk("et_lat7x3", 64'(et_lat(1'b0, 32'd3)), 64'd2);
    do_op(1'b1, 32'hFFFFFFFB, 32'd6, 64'hFFFFFFFF_FFFFFFE2, "s_m5x6");
    do_op(1'b0, 32'hFFFFFFFB, 32'd6, 64'h00000005_FFFFFFE2, "u_m5x6");
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "u_ones");
    do_op(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "s_minmin");
    do_op(1'b1, 32'h0, 32'h80000000, 64'd0, "zero_m");
    do_op(1'b1, 32'h12345678, 32'h0, 64'd0, "zero_q");

    // start held through RUN with new operands must not disturb the op
    launch(1'b0, 32'd7, 32'h80000003);
    start  = 1'b1;
    mcand  = 32'd100;
    mplier = 32'd200;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_done(lat);
    chk("hold_lat", 64'(lat + 8), 64'd17);
    chk("hold_prod", {prod_hi, prod_lo}, ref_mul(1'b0, 32'd7, 32'h80000003));
    @(posedge clk);
    #1;

    // back-to-back: start accepted in the DONE cycle
    launch(1'b1, 32'hDEADBEEF, 32'h80001234);
    wait_done(lat);
    chk("b2b_a", {prod_hi, prod_lo}, ref_mul(1'b1, 32'hDEADBEEF, 32'h80001234));
    start     = 1'b1;
    signed_op = 1'b0;
    mcand     = 32'hCAFEF00D;
    mplier    = 32'h9ABCDEF1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_hold", {prod_hi, prod_lo}, ref_mul(1'b1, 32'hDEADBEEF, 32'h80001234));
    wait_done(lat);
    chk("b2b_lat", 64'(lat), 64'(exp_lat(1'b0, 32'h9ABCDEF1)));
    chk("b2b_b", {prod_hi, prod_lo}, ref_mul(1'b0, 32'hCAFEF00D, 32'h9ABCDEF1));
    @(posedge clk);
    #1;

    // asynchronous abort mid-RUN
    launch(1'b0, 32'h00001234, 32'h80005678);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    #2;
    clr = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_prod", {prod_hi, prod_lo}, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    saw = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      saw = saw | done;
    end
    chk("abort_nodone", 64'(saw), 64'd0);
    do_op(1'b0, 32'd12, 32'd12, 64'd144, "after_clr");

    for (int i = 0; i < 2000; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) a = corner[$urandom_range(0, 5)];
      if (i % 8 == 1) b = corner[$urandom_range(0, 5)];
      if (i % 8 == 2) b = $urandom_range(0, 255);
      do_op(s, a, b, ref_mul(s, a, b), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
